// File: rtl/adat_pkg.sv
// Shared types and constants for the ADAT<->USB bridge clock sequencing.
//   fs_seq_state_t : state encoding of fs_clock_sequencer (also exported on state_o)
//   FS_48K/FS_44K  : values of the xtal mux select / fs_sel request
package adat_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StMute     = 3'd1,
    StSwitch   = 3'd2,
    StWaitLock = 3'd3,
    StSettle   = 3'd4,
    StAlign    = 3'd5,
    StRun      = 3'd6
  } fs_seq_state_t;

  localparam logic FS_48K = 1'b0;
  localparam logic FS_44K = 1'b1;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous input with registered edge pulses.
//   clk_i, rst_ni : destination clock, asynchronous active-low reset
//   d_i           : asynchronous input
//   level_o       : synchronised level (SYNC_STAGES cycles of latency)
//   rise_o/fall_o : one-cycle pulses, registered one cycle after the level changes
module sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] chain_q, chain_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    chain_d = {chain_q[SYNC_STAGES-2:0], d_i};
    prev_d  = chain_q[SYNC_STAGES-1];
    rise_d  = chain_q[SYNC_STAGES-1] & ~prev_q;
    fall_d  = ~chain_q[SYNC_STAGES-1] & prev_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = chain_q[SYNC_STAGES-1];
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/fs_clock_sequencer.sv
// Sequences sample-rate changes and I2S (re)starts: mutes ADAT, switches the 44.1k/48k xtal
// mux, pulses the PLL reset, waits for a stable lock, then enables I2S on a word-clock edge.
//   clk_i, rst_ni        : free-running xtal clock, asynchronous active-low reset
//   mcu_ready_i          : async, MCU ready; low forces IDLE
//   fs_sel_i             : async, requested rate (0 = 48 kHz, 1 = 44.1 kHz)
//   i2s_resync_req_i     : async, rising edge requests a full restart
//   pll_locked_i         : async, PLL lock indicator
//   word_clk_i           : async, current word clock
//   sel_clk_o, pll_rst_o : xtal mux select, PLL reset
//   mute_o, i2s_en_o     : ADAT mute, I2S serialiser enable
//   i2s_running_o        : sequence complete
//   lock_err_o           : sticky lock-timeout flag
//   state_o              : current state encoding
module fs_clock_sequencer
  import adat_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned MUTE_CYCLES    = 256,
  parameter int unsigned PLL_RST_CYCLES = 64,
  parameter int unsigned SETTLE_CYCLES  = 4096,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       mcu_ready_i,
  input  logic       fs_sel_i,
  input  logic       i2s_resync_req_i,
  input  logic       pll_locked_i,
  input  logic       word_clk_i,
  output logic       sel_clk_o,
  output logic       pll_rst_o,
  output logic       mute_o,
  output logic       i2s_en_o,
  output logic       i2s_running_o,
  output logic       lock_err_o,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] MuteLast    = CNT_W'(MUTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PllRstLast  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);

  logic mcu_lvl, mcu_rise, mcu_fall;
  logic fs_lvl, fs_rise, fs_fall;
  logic rs_lvl, rs_rise, rs_fall;
  logic lk_lvl, lk_rise, lk_fall;
  logic wc_lvl, wc_rise, wc_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mcu (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(mcu_ready_i),
    .level_o(mcu_lvl), .rise_o(mcu_rise), .fall_o(mcu_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_fs (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(fs_sel_i),
    .level_o(fs_lvl), .rise_o(fs_rise), .fall_o(fs_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_resync (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(i2s_resync_req_i),
    .level_o(rs_lvl), .rise_o(rs_rise), .fall_o(rs_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(pll_locked_i),
    .level_o(lk_lvl), .rise_o(lk_rise), .fall_o(lk_fall)
  );
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wclk (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(word_clk_i),
    .level_o(wc_lvl), .rise_o(wc_rise), .fall_o(wc_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{mcu_rise, mcu_fall, fs_rise, fs_fall, rs_lvl, rs_fall,
                          lk_rise, lk_fall, wc_lvl, wc_fall};

  fs_seq_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_clk_q, sel_clk_d;
  logic             pll_rst_q, pll_rst_d;
  logic             mute_q, mute_d;
  logic             i2s_en_q, i2s_en_d;
  logic             running_q, running_d;
  logic             lock_err_q, lock_err_d;
  logic             trig;

  always_comb begin
    state_d    = state_q;
    sel_clk_d  = sel_clk_q;
    pll_rst_d  = pll_rst_q;
    mute_d     = mute_q;
    i2s_en_d   = i2s_en_q;
    running_d  = running_q;
    lock_err_d = lock_err_q;

    // Rate mismatch is judged against the mux setting actually applied.
    trig = (fs_lvl != sel_clk_q) || rs_rise;

    if (!mcu_lvl) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StSwitch;
        StMute:   if (cnt_q == MuteLast) state_d = StSwitch;
        StSwitch: begin
          if (trig)                      state_d = StMute;
          else if (cnt_q == PllRstLast)  state_d = StWaitLock;
        end
        StWaitLock: begin
          if (trig)                      state_d = StMute;
          else if (lk_lvl)               state_d = StSettle;
          else if (cnt_q == TimeoutLast) begin
            state_d    = StSwitch;
            lock_err_d = 1'b1;
          end
        end
        StSettle: begin
          if (!lk_lvl)                   state_d = StWaitLock;
          else if (trig)                 state_d = StMute;
          else if (cnt_q == SettleLast)  state_d = StAlign;
        end
        StAlign: begin
          if (trig)                      state_d = StMute;
          else if (wc_rise)              state_d = StRun;
        end
        StRun:    if (!lk_lvl || trig) state_d = StMute;
        default:  state_d = StIdle;
      endcase
    end

    // Every state entry (including a timeout retry into SWITCH) restarts the shared counter.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    // Outputs are registered alongside the state they belong to.
    unique case (state_d)
      StIdle: begin
        pll_rst_d = 1'b1;
        mute_d    = 1'b1;
        i2s_en_d  = 1'b0;
        running_d = 1'b0;
      end
      StMute: begin
        mute_d    = 1'b1;
        i2s_en_d  = 1'b0;
        running_d = 1'b0;
      end
      StSwitch: begin
        pll_rst_d = 1'b1;
        mute_d    = 1'b1;
        i2s_en_d  = 1'b0;
        running_d = 1'b0;
        // Latch the newest request on entry so mid-sequence changes end on the latest rate.
        if (state_q != StSwitch) sel_clk_d = fs_lvl;
      end
      StWaitLock: pll_rst_d = 1'b0;
      StRun: begin
        i2s_en_d = 1'b1;
        if (state_q == StRun) begin
          running_d = 1'b1;
          mute_d    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      sel_clk_q  <= FS_48K;
      pll_rst_q  <= 1'b1;
      mute_q     <= 1'b1;
      i2s_en_q   <= 1'b0;
      running_q  <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_clk_q  <= sel_clk_d;
      pll_rst_q  <= pll_rst_d;
      mute_q     <= mute_d;
      i2s_en_q   <= i2s_en_d;
      running_q  <= running_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign sel_clk_o     = sel_clk_q;
  assign pll_rst_o     = pll_rst_q;
  assign mute_o        = mute_q;
  assign i2s_en_o      = i2s_en_q;
  assign i2s_running_o = running_q;
  assign lock_err_o    = lock_err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_fs_clock_sequencer.sv
// Directed bench for fs_clock_sequencer (LOCK_TIMEOUT shortened to 1000 cycles).
module tb_fs_clock_sequencer;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StMute     = 3'd1;
  localparam logic [2:0] StSwitch   = 3'd2;
  localparam logic [2:0] StWaitLock = 3'd3;
  localparam logic [2:0] StSettle   = 3'd4;
  localparam logic [2:0] StAlign    = 3'd5;
  localparam logic [2:0] StRun      = 3'd6;

  logic       clk, rst_ni;
  logic       mcu_ready, fs_sel, resync_req, pll_locked, word_clk;
  logic       sel_clk, pll_rst, mute, i2s_en, i2s_running, lock_err;
  logic [2:0] state;

  int n_cmp  = 0;
  int n_fail = 0;
  int wc_cyc = 0;
  int wc_age = 0;

  fs_clock_sequencer #(.LOCK_TIMEOUT(1000)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .mcu_ready_i(mcu_ready), .fs_sel_i(fs_sel),
    .i2s_resync_req_i(resync_req), .pll_locked_i(pll_locked), .word_clk_i(word_clk),
    .sel_clk_o(sel_clk), .pll_rst_o(pll_rst), .mute_o(mute), .i2s_en_o(i2s_en),
    .i2s_running_o(i2s_running), .lock_err_o(lock_err), .state_o(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word clock: period 64 clk cycles, changes 2 ns after a rising edge.
  // wc_age counts rising clk edges since the last word-clock rise.
  initial begin
    word_clk = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      wc_cyc++;
      wc_age++;
      if (wc_cyc == 32) begin
        wc_cyc   = 0;
        word_clk = ~word_clk;
        if (word_clk) wc_age = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n, output bit ok);
    n = 0;
    while (state !== s && n < budget) begin
      tick(1);
      n++;
    end
    ok = (state === s);
  endtask

  task automatic count_state(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (state === s && n < budget) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_ni = 1'b0; mcu_ready = 1'b0; fs_sel = 1'b0; resync_req = 1'b0; pll_locked = 1'b0;
    tick(3);
    n_cmp++; if ({sel_clk, pll_rst, mute, i2s_en, i2s_running, lock_err} !== 6'b011000) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 011000",
                         {sel_clk, pll_rst, mute, i2s_en, i2s_running, lock_err});
    end
    n_cmp++; if (state !== StIdle) begin
      n_fail++; $display("FAIL reset_state: got %0d want %0d", state, StIdle);
    end
    rst_ni = 1'b1;
    tick(5);
    n_cmp++; if (state !== StIdle || pll_rst !== 1'b1) begin
      n_fail++; $display("FAIL idle_hold: state %0d pll_rst %b want 0/1", state, pll_rst);
    end
  endtask

  task automatic test_bringup;
    int n;
    bit ok;
    mcu_ready = 1'b1;
    wait_state(StSwitch, 10, n, ok);
    n_cmp++; if (n !== 3) begin
      n_fail++; $display("FAIL bringup_latency: got %0d want 3", n);
    end
    n_cmp++; if (sel_clk !== 1'b0 || pll_rst !== 1'b1) begin
      n_fail++; $display("FAIL bringup_switch: sel %b pll_rst %b want 0/1", sel_clk, pll_rst);
    end
    count_state(StSwitch, 100, n);
    n_cmp++; if (n !== 64) begin
      n_fail++; $display("FAIL switch_len: got %0d want 64", n);
    end
    n_cmp++; if (state !== StWaitLock || pll_rst !== 1'b0) begin
      n_fail++; $display("FAIL wait_lock_entry: state %0d pll_rst %b want 3/0", state, pll_rst);
    end
    tick(100);
    pll_locked = 1'b1;
    wait_state(StSettle, 10, n, ok);
    n_cmp++; if (n !== 3) begin
      n_fail++; $display("FAIL lock_latency: got %0d want 3", n);
    end
    count_state(StSettle, 5000, n);
    n_cmp++; if (n !== 4096) begin
      n_fail++; $display("FAIL settle_len: got %0d want 4096", n);
    end
    count_state(StAlign, 100, n);
    n_cmp++; if (n < 1 || n > 64) begin
      n_fail++; $display("FAIL align_len: got %0d want 1..64", n);
    end
    n_cmp++; if (state !== StRun || i2s_en !== 1'b1 || mute !== 1'b1 || i2s_running !== 1'b0) begin
      n_fail++; $display("FAIL run_entry: state %0d en %b mute %b run %b want 6/1/1/0",
                         state, i2s_en, mute, i2s_running);
    end
    n_cmp++; if (wc_age !== 4) begin
      n_fail++; $display("FAIL align_edge: got age %0d want 4", wc_age);
    end
    tick(1);
    n_cmp++; if (i2s_running !== 1'b1 || mute !== 1'b0 || sel_clk !== 1'b0) begin
      n_fail++; $display("FAIL run_steady: run %b mute %b sel %b want 1/0/0",
                         i2s_running, mute, sel_clk);
    end
  endtask

  task automatic test_fs_change;
    int n;
    bit ok;
    fs_sel = 1'b1;
    tick(2);
    n_cmp++; if (mute !== 1'b0) begin
      n_fail++; $display("FAIL fs_mute_early: got %b want 0", mute);
    end
    tick(1);
    n_cmp++; if (mute !== 1'b1 || i2s_en !== 1'b0 || state !== StMute) begin
      n_fail++; $display("FAIL fs_mute: mute %b en %b state %0d want 1/0/1", mute, i2s_en, state);
    end
    count_state(StMute, 400, n);
    n_cmp++; if (n !== 256) begin
      n_fail++; $display("FAIL mute_len: got %0d want 256", n);
    end
    n_cmp++; if (state !== StSwitch || sel_clk !== 1'b1) begin
      n_fail++; $display("FAIL fs_switch: state %0d sel %b want 2/1", state, sel_clk);
    end
    wait_state(StRun, 5000, n, ok);
    tick(1);
    n_cmp++; if (!ok || i2s_running !== 1'b1 || sel_clk !== 1'b1) begin
      n_fail++; $display("FAIL fs_run: ok %b run %b sel %b want 1/1/1", ok, i2s_running, sel_clk);
    end
  endtask

  task automatic test_lock_timeout;
    int n;
    bit ok;
    pll_locked = 1'b0;
    wait_state(StMute, 10, n, ok);
    n_cmp++; if (n !== 3) begin
      n_fail++; $display("FAIL lockdrop_latency: got %0d want 3", n);
    end
    wait_state(StWaitLock, 400, n, ok);
    n_cmp++; if (!ok || lock_err !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pre: ok %b lock_err %b want 1/0", ok, lock_err);
    end
    count_state(StWaitLock, 1100, n);
    n_cmp++; if (n !== 1000) begin
      n_fail++; $display("FAIL timeout_len: got %0d want 1000", n);
    end
    n_cmp++; if (state !== StSwitch || lock_err !== 1'b1 || pll_rst !== 1'b1) begin
      n_fail++; $display("FAIL timeout_retry: state %0d err %b pll_rst %b want 2/1/1",
                         state, lock_err, pll_rst);
    end
    count_state(StSwitch, 100, n);
    n_cmp++; if (n !== 64) begin
      n_fail++; $display("FAIL retry_pll_rst_len: got %0d want 64", n);
    end
    tick(10);
    pll_locked = 1'b1;
    wait_state(StRun, 5000, n, ok);
    n_cmp++; if (!ok || lock_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_recover: ok %b lock_err %b want 1/1", ok, lock_err);
    end
    tick(1);
  endtask

  task automatic test_resync_glitch;
    int n;
    bit ok;
    resync_req = 1'b1;
    tick(4);
    resync_req = 1'b0;
    wait_state(StMute, 5, n, ok);
    n_cmp++; if (!ok || mute !== 1'b1) begin
      n_fail++; $display("FAIL resync_mute: ok %b mute %b want 1/1", ok, mute);
    end
    wait_state(StSettle, 500, n, ok);
    n_cmp++; if (!ok || sel_clk !== 1'b1) begin
      n_fail++; $display("FAIL resync_sel: ok %b sel %b want 1/1", ok, sel_clk);
    end
    tick(2000);
    n_cmp++; if (state !== StSettle) begin
      n_fail++; $display("FAIL settle_mid: got %0d want %0d", state, StSettle);
    end
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_state(StWaitLock, 5, n, ok);
    n_cmp++; if (!ok) begin
      n_fail++; $display("FAIL glitch_waitlock: state %0d want %0d", state, StWaitLock);
    end
    count_state(StWaitLock, 10, n);
    n_cmp++; if (n !== 1) begin
      n_fail++; $display("FAIL glitch_waitlock_len: got %0d want 1", n);
    end
    count_state(StSettle, 5000, n);
    n_cmp++; if (n !== 4096) begin
      n_fail++; $display("FAIL glitch_resettle_len: got %0d want 4096", n);
    end
    wait_state(StRun, 100, n, ok);
    tick(1);
  endtask

  task automatic test_fs_toggle;
    int n;
    bit ok;
    resync_req = 1'b1;
    tick(4);
    resync_req = 1'b0;
    wait_state(StSettle, 500, n, ok);
    tick(50);
    fs_sel = 1'b0;
    tick(1);
    fs_sel = 1'b1;
    wait_state(StMute, 10, n, ok);
    n_cmp++; if (!ok) begin
      n_fail++; $display("FAIL toggle_mute: state %0d want %0d", state, StMute);
    end
    wait_state(StSwitch, 300, n, ok);
    n_cmp++; if (!ok || sel_clk !== 1'b1) begin
      n_fail++; $display("FAIL toggle_switch: ok %b sel %b want 1/1", ok, sel_clk);
    end
    wait_state(StRun, 5000, n, ok);
    tick(1);
    n_cmp++; if (!ok || sel_clk !== 1'b1 || i2s_running !== 1'b1) begin
      n_fail++; $display("FAIL toggle_run: ok %b sel %b run %b want 1/1/1",
                         ok, sel_clk, i2s_running);
    end
  endtask

  task automatic test_mcu_drop;
    int n;
    bit ok;
    mcu_ready = 1'b0;
    tick(3);
    n_cmp++; if (state !== StIdle) begin
      n_fail++; $display("FAIL mcu_drop_state: got %0d want %0d", state, StIdle);
    end
    n_cmp++; if ({sel_clk, pll_rst, mute, i2s_en, i2s_running, lock_err} !== 6'b111001) begin
      n_fail++; $display("FAIL mcu_drop_outputs: got %b want 111001",
                         {sel_clk, pll_rst, mute, i2s_en, i2s_running, lock_err});
    end
    mcu_ready = 1'b1;
    wait_state(StSwitch, 10, n, ok);
    n_cmp++; if (n !== 3) begin
      n_fail++; $display("FAIL mcu_restart_nomute: got %0d want 3", n);
    end
  endtask

  task automatic test_async_reset;
    int n;
    bit ok;
    wait_state(StSettle, 200, n, ok);
    tick(100);
    #3;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if ({sel_clk, pll_rst, mute, i2s_en, i2s_running, lock_err} !== 6'b011000) begin
      n_fail++; $display("FAIL async_reset_outputs: got %b want 011000",
                         {sel_clk, pll_rst, mute, i2s_en, i2s_running, lock_err});
    end
    n_cmp++; if (state !== StIdle) begin
      n_fail++; $display("FAIL async_reset_state: got %0d want %0d", state, StIdle);
    end
    tick(2);
    rst_ni = 1'b1;
    wait_state(StSwitch, 10, n, ok);
    n_cmp++; if (n !== 3 || sel_clk !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_switch: n %0d sel %b want 3/1", n, sel_clk);
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_fs_change();
    test_lock_timeout();
    test_resync_glitch();
    test_fs_toggle();
    test_mcu_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
